param_updown_counter: RTL and testbench

PARAM_UPDOWN_COUNTER -- requirements
Module: param_updown_counter

---
 rtl/cnt_pkg.sv | 14 +
 rtl/cnt_prescaler.sv | 35 +++
 rtl/param_updown_counter.sv | 93 +++++++++
 tb/tb_param_updown_counter.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared FSM state and direction/mode encodings for the up/down counter.
package cnt_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    DONE = 1'b1
  } cnt_state_t;

  localparam logic DIR_DOWN     = 1'b0;
  localparam logic DIR_UP       = 1'b1;
  localparam logic MODE_RELOAD  = 1'b0;
  localparam logic MODE_ONESHOT = 1'b1;

endpackage

// File: rtl/cnt_prescaler.sv
// Enabled-cycle divider: step is combinational, high on every (prescale+1)th active cycle.
// clr restarts the period and wins over active.
module cnt_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       active,
  input  logic       clr,
  input  logic [7:0] prescale,
  output logic       step
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // >= keeps the period bounded if prescale is lowered below the running count
  assign step = active && (cnt_q >= prescale);

  always_comb begin
    cnt_d = cnt_q;
    if (clr || step) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/param_updown_counter.sv
// Up/down counter with auto-reload or one-shot terminal handling; count/tc registered, one cycle latency.
// Optional prescale input under COUNTER_PRESCALE_EN; load overrides en, DONE ignores en.
module param_updown_counter
  import cnt_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
`ifdef COUNTER_PRESCALE_EN
  input  logic [7:0]       prescale,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  cnt_state_t       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;

  logic             active;
  logic             step;
  logic             at_term;
  logic             enter_done;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] reload_val;

  assign active     = en && (state_q == RUN) && !load;
  assign term_val   = (dir == DIR_UP) ? limit : '0;
  assign reload_val = (dir == DIR_DOWN) ? limit : '0;
  assign at_term    = (count_q == term_val);
  assign enter_done = step && at_term && (mode == MODE_ONESHOT);

`ifdef COUNTER_PRESCALE_EN
  cnt_prescaler u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .active   (active),
    .clr      (load || enter_done),
    .prescale (prescale),
    .step     (step)
  );
`else
  assign step = active;
`endif

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    state_d = state_q;
    if (load) begin
      count_d = load_val;
      state_d = RUN;
    end else if (step) begin
      tc_d = at_term;
      if (!at_term) begin
        count_d = (dir == DIR_UP) ? count_q + ONE : count_q - ONE;
      end else if (mode == MODE_RELOAD) begin
        count_d = reload_val;
      end
      if (enter_done) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter at WIDTH=4; prescale steps run only with COUNTER_PRESCALE_EN.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] load_val;
  logic       dir;
  logic       mode;
  logic [3:0] limit;
  logic [3:0] count;
  logic       tc;
  logic       busy;
`ifdef COUNTER_PRESCALE_EN
  logic [7:0] prescale;
`endif

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  param_updown_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .mode     (mode),
    .limit    (limit),
`ifdef COUNTER_PRESCALE_EN
    .prescale (prescale),
`endif
    .count    (count),
    .tc       (tc),
    .busy     (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [3:0] c, input logic t, input logic b);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".tc"},    32'(tc),    32'(t));
    check({tag, ".busy"},  32'(busy),  32'(b));
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 4'd0;
    dir = 1'b0; mode = 1'b0; limit = 4'd9;
`ifdef COUNTER_PRESCALE_EN
    prescale = 8'd0;
`endif
    #1 rst = 1'b0;
    #1 check_state("reset_async", 4'd15, 1'b0, 1'b1);
    tick();
    check_state("reset_held", 4'd15, 1'b0, 1'b1);

    // Down-count from reset value with auto-reload to limit=9
    rst = 1'b1; en = 1'b1;
    for (int i = 14; i >= 0; i--) begin
      tick();
      check_state("down_seq", 4'(i), 1'b0, 1'b1);
    end
    tick();
    check_state("down_reload", 4'd9, 1'b1, 1'b1);
    tick();
    check_state("down_after", 4'd8, 1'b0, 1'b1);

    // One-shot up-count to limit=5
    load = 1'b1; load_val = 4'd3; dir = 1'b1; mode = 1'b1; limit = 4'd5;
    tick();
    check_state("os_load", 4'd3, 1'b0, 1'b1);
    load = 1'b0;
    tick(); check_state("os_4", 4'd4, 1'b0, 1'b1);
    tick(); check_state("os_5", 4'd5, 1'b0, 1'b1);
    tick(); check_state("os_tc", 4'd5, 1'b1, 1'b0);
    tick(); check_state("os_hold1", 4'd5, 1'b0, 1'b0);
    tick(); check_state("os_hold2", 4'd5, 1'b0, 1'b0);

    // Load with en in DONE, then load over en in RUN
    load = 1'b1; load_val = 4'd7; mode = 1'b0; limit = 4'd15;
    tick(); check_state("done_load", 4'd7, 1'b0, 1'b1);
    tick(); check_state("load_prio", 4'd7, 1'b0, 1'b1);
    load = 1'b0;
    tick(); check_state("after_load", 4'd8, 1'b0, 1'b1);

    // Hold with en=0
    en = 1'b0;
    tick(); check_state("hold_en0", 4'd8, 1'b0, 1'b1);

    // Reach count=6 with tc high, then asynchronous reset
    load = 1'b1; load_val = 4'd0; dir = 1'b0; limit = 4'd6;
    tick(); check_state("pre_rst_load", 4'd0, 1'b0, 1'b1);
    load = 1'b0; en = 1'b1;
    tick(); check_state("pre_rst_tc", 4'd6, 1'b1, 1'b1);
    #2 rst = 1'b0;
    #1 check_state("mid_rst", 4'd15, 1'b0, 1'b1);
    tick(); check_state("mid_rst_held", 4'd15, 1'b0, 1'b1);
    rst = 1'b1;
    tick(); check_state("rst_resume", 4'd14, 1'b0, 1'b1);

    // Up-count above limit wraps through 15 to 0, then reaches limit=2
    load = 1'b1; load_val = 4'd14; dir = 1'b1; mode = 1'b0; limit = 4'd2;
    tick(); check_state("wrap_load", 4'd14, 1'b0, 1'b1);
    load = 1'b0;
    tick(); check_state("wrap_15", 4'd15, 1'b0, 1'b1);
    tick(); check_state("wrap_0", 4'd0, 1'b0, 1'b1);
    tick(); check_state("wrap_1", 4'd1, 1'b0, 1'b1);
    tick(); check_state("wrap_2", 4'd2, 1'b0, 1'b1);
    tick(); check_state("wrap_tc", 4'd0, 1'b1, 1'b1);
    tick(); check_state("wrap_after", 4'd1, 1'b0, 1'b1);

    // limit=0 down auto-reload: tc on every step
    load = 1'b1; load_val = 4'd0; dir = 1'b0; limit = 4'd0;
    tick(); check_state("lim0_load", 4'd0, 1'b0, 1'b1);
    load = 1'b0;
    tick(); check_state("lim0_tc1", 4'd0, 1'b1, 1'b1);
    tick(); check_state("lim0_tc2", 4'd0, 1'b1, 1'b1);

`ifdef COUNTER_PRESCALE_EN
    // Prescale=2: one step per three enabled cycles; load restarts the period
    load = 1'b1; load_val = 4'd0; dir = 1'b1; limit = 4'd15; prescale = 8'd2;
    tick(); check_state("ps_load", 4'd0, 1'b0, 1'b1);
    load = 1'b0;
    tick(); check_state("ps_c1", 4'd0, 1'b0, 1'b1);
    tick(); check_state("ps_c2", 4'd0, 1'b0, 1'b1);
    tick(); check_state("ps_c3", 4'd1, 1'b0, 1'b1);
    tick(); check_state("ps_c4", 4'd1, 1'b0, 1'b1);
    load = 1'b1; load_val = 4'd8;
    tick(); check_state("ps_reload", 4'd8, 1'b0, 1'b1);
    load = 1'b0;
    tick(); check_state("ps_r1", 4'd8, 1'b0, 1'b1);
    tick(); check_state("ps_r2", 4'd8, 1'b0, 1'b1);
    tick(); check_state("ps_r3", 4'd9, 1'b0, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
